// File: rtl/render_cfg_pkg.sv
// Shared constants, region types and the address decoder for render_cfg_regs.
// Optional feature macro: RENDER_CFG_IRQ_EN (adds the irq output and IRQ_EN register).
package render_cfg_pkg;

  // Byte offsets of the scalar registers within the low 256-byte page
  localparam logic [7:0] OFF_FB_BASE   = 8'h00;
  localparam logic [7:0] OFF_VB_BASE   = 8'h04;
  localparam logic [7:0] OFF_CTRL      = 8'h08;
  localparam logic [7:0] OFF_STATUS    = 8'h0C;
  localparam logic [7:0] OFF_FRAME_CNT = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h14;

  // Register bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;
  localparam int IRQ_EN_DONE_BIT = 0;
  localparam int IRQ_EN_ERR_BIT  = 1;

  // Launch sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  typedef enum logic [3:0] {
    RGN_NONE,
    RGN_FB,
    RGN_VB,
    RGN_CTRL,
    RGN_STATUS,
    RGN_FCNT,
    RGN_IRQEN,
    RGN_MAT,
    RGN_LIGHT
  } region_t;

  typedef struct packed {
    region_t    region;
    logic [7:0] sel;
    logic [7:0] word;
  } addr_dec_t;

  // Page 0 holds scalar registers, pages 1..num_mat hold matrices and the
  // following page holds the lighting words; anything else is unmapped.
  function automatic addr_dec_t decode_addr(input logic [29:0] word_addr,
                                            input logic [31:0] num_mat,
                                            input logic [31:0] mat_words,
                                            input logic [31:0] light_words);
    addr_dec_t d;
    logic [31:0] page;
    logic [31:0] woff;
    d.region = RGN_NONE;
    d.sel    = '0;
    d.word   = '0;
    page = 32'(word_addr[29:6]);
    woff = 32'(word_addr[5:0]);
    if (page == 32'd0) begin
      case ({word_addr[5:0], 2'b00})
        OFF_FB_BASE:   d.region = RGN_FB;
        OFF_VB_BASE:   d.region = RGN_VB;
        OFF_CTRL:      d.region = RGN_CTRL;
        OFF_STATUS:    d.region = RGN_STATUS;
        OFF_FRAME_CNT: d.region = RGN_FCNT;
        OFF_IRQ_EN:    d.region = RGN_IRQEN;
        default:       d.region = RGN_NONE;
      endcase
    end else if (page <= num_mat) begin
      if (woff < mat_words) begin
        d.region = RGN_MAT;
        d.sel    = 8'(page - 32'd1);
        d.word   = 8'(woff);
      end
    end else if (page == num_mat + 32'd1) begin
      if (woff < light_words) begin
        d.region = RGN_LIGHT;
        d.word   = 8'(woff);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/render_cfg_regs_cfg_shadow_bank.sv
// Word array with a host-visible shadow copy and a pipeline-visible active
// copy; commit copies every shadow word into active in one cycle.
module cfg_shadow_bank
  import render_cfg_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [7:0]              wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [7:0]              rd_idx,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    commit,
  output logic [WORDS*DATA_W-1:0] active
);

  logic [DATA_W-1:0] shadow [WORDS];

  // Commit samples the shadow before any same-cycle host write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        shadow[i]                  <= RESET_VAL;
        active[i*DATA_W +: DATA_W] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (commit) active[i*DATA_W +: DATA_W] <= shadow[i];
        if (wr_en && (wr_idx == 8'(i))) shadow[i] <= wr_data;
      end
    end
  end

  // Host reads see the shadow copy
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (rd_idx == 8'(i)) rd_data = shadow[i];
    end
  end

endmodule

// File: rtl/render_cfg_regs.sv
// Double-buffered Avalon-MM configuration register file for the 3D renderer,
// with the START/busy/done launch sequencer and frame counter.
// Optional feature macro: RENDER_CFG_IRQ_EN (irq output plus IRQ_EN at 0x014).
module render_cfg_regs
  import render_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int BASE_W = 26,
  parameter int NUM_MAT = 2,
  parameter int MAT_WORDS = 16,
  parameter int LIGHT_WORDS = 3,
  parameter logic [BASE_W-1:0] VB_RESET = 26'h300000,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 address,
  input  logic                              write,
  input  logic [DATA_W-1:0]                 writedata,
  input  logic                              read,
  output logic [DATA_W-1:0]                 readdata,
  output logic                              readdatavalid,
  output logic [BASE_W-1:0]                 fb_base,
  output logic [BASE_W-1:0]                 vb_base,
  output logic [NUM_MAT*MAT_WORDS*DATA_W-1:0] mat,
  output logic [LIGHT_WORDS*DATA_W-1:0]     lighting,
  output logic                              render_go,
  input  logic                              render_done,
  output logic                              busy
`ifdef RENDER_CFG_IRQ_EN
  ,
  output logic                              irq
`endif
);

`ifdef RENDER_CFG_IRQ_EN
  localparam bit IRQ_FEATURE = 1'b1;
`else
  localparam bit IRQ_FEATURE = 1'b0;
`endif

  addr_dec_t dec;
  logic unused_addr_bits;
  logic [1:0] state;
  logic [1:0] state_next;
  logic commit;
  logic [BASE_W-1:0] fb_shadow;
  logic [BASE_W-1:0] vb_shadow;
  logic done;
  logic err;
  logic [CNT_W-1:0] frame_cnt;
  logic start_req;
  logic start_accept;
  logic start_reject;
  logic status_wr;
  logic wr_unmapped;
  logic frame_end;
  logic [DATA_W-1:0] mat_rd [NUM_MAT];
  logic [DATA_W-1:0] light_rd;
  logic [DATA_W-1:0] rd_mux;

  assign unused_addr_bits = ^address[1:0];
  assign dec = decode_addr(30'(address[ADDR_W-1:2]), 32'(NUM_MAT), 32'(MAT_WORDS),
                           32'(LIGHT_WORDS));

  assign commit       = (state == ST_COMMIT);
  assign busy         = (state != ST_IDLE);
  assign start_req    = write && (dec.region == RGN_CTRL) && writedata[CTRL_START_BIT];
  assign start_accept = start_req && (state == ST_IDLE);
  assign start_reject = start_req && (state != ST_IDLE);
  assign status_wr    = write && (dec.region == RGN_STATUS);
  assign frame_end    = (state == ST_RUN) && render_done;
  assign wr_unmapped  = write && ((dec.region == RGN_NONE) || (dec.region == RGN_FCNT) ||
                                  ((dec.region == RGN_IRQEN) && !IRQ_FEATURE));

  // Launch sequencer: IDLE waits for START, COMMIT lasts one cycle, RUN waits for done
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_accept) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_RUN;
      ST_RUN:    if (render_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register; render_go is registered so it is high exactly in the COMMIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      render_go <= 1'b0;
    end else begin
      state     <= state_next;
      render_go <= (state_next == ST_COMMIT);
    end
  end

  // Buffer base shadow/active pairs, kept inline because they are narrower than a bus word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_shadow <= '0;
      fb_base   <= '0;
      vb_shadow <= VB_RESET;
      vb_base   <= VB_RESET;
    end else begin
      if (commit) begin
        fb_base <= fb_shadow;
        vb_base <= vb_shadow;
      end
      if (write && (dec.region == RGN_FB)) fb_shadow <= writedata[BASE_W-1:0];
      if (write && (dec.region == RGN_VB)) vb_shadow <= writedata[BASE_W-1:0];
    end
  end

  // Sticky status bits and frame counter; a new set beats a simultaneous W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (frame_end) done <= 1'b1;
      else if (status_wr && writedata[STATUS_DONE_BIT]) done <= 1'b0;
      if (wr_unmapped || start_reject) err <= 1'b1;
      else if (status_wr && writedata[STATUS_ERR_BIT]) err <= 1'b0;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  for (genvar m = 0; m < NUM_MAT; m++) begin : g_mat
    cfg_shadow_bank #(
      .WORDS(MAT_WORDS),
      .DATA_W(DATA_W),
      .RESET_VAL({DATA_W{1'b0}})
    ) u_bank (
      .clk(clk),
      .reset(reset),
      .wr_en(write && (dec.region == RGN_MAT) && (dec.sel == 8'(m))),
      .wr_idx(dec.word),
      .wr_data(writedata),
      .rd_idx(dec.word),
      .rd_data(mat_rd[m]),
      .commit(commit),
      .active(mat[m*MAT_WORDS*DATA_W +: MAT_WORDS*DATA_W])
    );
  end

  cfg_shadow_bank #(
    .WORDS(LIGHT_WORDS),
    .DATA_W(DATA_W),
    .RESET_VAL({DATA_W{1'b0}})
  ) u_light (
    .clk(clk),
    .reset(reset),
    .wr_en(write && (dec.region == RGN_LIGHT)),
    .wr_idx(dec.word),
    .wr_data(writedata),
    .rd_idx(dec.word),
    .rd_data(light_rd),
    .commit(commit),
    .active(lighting)
  );

`ifdef RENDER_CFG_IRQ_EN
  logic [1:0] irq_en;

  // Interrupt enable register and registered interrupt line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (write && (dec.region == RGN_IRQEN)) irq_en <= writedata[1:0];
      irq <= (irq_en[IRQ_EN_DONE_BIT] && done) || (irq_en[IRQ_EN_ERR_BIT] && err);
    end
  end
`endif

  // Read mux: shadow values for configuration, live values for status and counter
  always_comb begin
    rd_mux = '0;
    case (dec.region)
      RGN_FB:     rd_mux = DATA_W'(fb_shadow);
      RGN_VB:     rd_mux = DATA_W'(vb_shadow);
      RGN_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = busy;
        rd_mux[STATUS_DONE_BIT] = done;
        rd_mux[STATUS_ERR_BIT]  = err;
      end
      RGN_FCNT:   rd_mux = DATA_W'(frame_cnt);
`ifdef RENDER_CFG_IRQ_EN
      RGN_IRQEN:  rd_mux = DATA_W'(irq_en);
`endif
      RGN_MAT: begin
        for (int m = 0; m < NUM_MAT; m++) begin
          if (dec.sel == 8'(m)) rd_mux = mat_rd[m];
        end
      end
      RGN_LIGHT:  rd_mux = light_rd;
      default:    rd_mux = '0;
    endcase
  end

  // One-cycle registered read response; the mux reflects pre-write state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_render_cfg_regs.sv
// Self-checking bench for render_cfg_regs: a register table plus frame
// sequences, with read responses checked against a scoreboard queue.
module tb_render_cfg_regs;

  logic clk;
  logic reset;
  logic [15:0] address;
  logic write;
  logic [31:0] writedata;
  logic read;
  logic [31:0] readdata;
  logic readdatavalid;
  logic [25:0] fb_base;
  logic [25:0] vb_base;
  logic [1023:0] mat;
  logic [95:0] lighting;
  logic render_go;
  logic render_done;
  logic busy;
`ifdef RENDER_CFG_IRQ_EN
  logic irq;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [15:0] addr;
    int unsigned due;
  } sb_t;

  sb_t sb [$];
  vec_t vecs [14];
  int compared = 0;
  int mismatched = 0;
  int go_count = 0;
  int unsigned cyc = 0;

  render_cfg_regs dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .write(write),
    .writedata(writedata),
    .read(read),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .fb_base(fb_base),
    .vb_base(vb_base),
    .mat(mat),
    .lighting(lighting),
    .render_go(render_go),
    .render_done(render_done),
    .busy(busy)
`ifdef RENDER_CFG_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every readdatavalid must match the oldest pending read, on time
  always @(negedge clk) begin
    if (!reset) begin
      if (render_go) go_count++;
      if (readdatavalid) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_rdv: got data 0x%08h with no pending read", readdata);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (readdata !== e.data || cyc != e.due) begin
            mismatched++;
            $display("[TB] FAIL read@%03h: got 0x%08h at cycle %0d, expected 0x%08h at cycle %0d",
                     e.addr, readdata, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rd);
    sb_t e;
    if (rd) begin
      e.data = exp_rd;
      e.addr = addr;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    address   = addr;
    write     = wr;
    read      = rd;
    writedata = wdata;
    tick();
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 32'h0);
  endtask

  task automatic busRead(input logic [15:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, exp);
  endtask

  task automatic pulseDone();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h000, 1'b1, 32'hFFFF_FFFF, 32'h03FF_FFFF};
    vecs[1]  = '{16'h004, 1'b1, 32'h1234_5678, 32'h0234_5678};
    vecs[2]  = '{16'h100, 1'b1, 32'h3F80_0000, 32'h3F80_0000};
    vecs[3]  = '{16'h13C, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4]  = '{16'h200, 1'b1, 32'h1111_0000, 32'h1111_0000};
    vecs[5]  = '{16'h23C, 1'b1, 32'h2222_FFFF, 32'h2222_FFFF};
    vecs[6]  = '{16'h300, 1'b1, 32'h0000_ABCD, 32'h0000_ABCD};
    vecs[7]  = '{16'h308, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[8]  = '{16'h30C, 1'b1, 32'h5555_5555, 32'h0000_0000};
    vecs[9]  = '{16'h140, 1'b1, 32'h6666_6666, 32'h0000_0000};
    vecs[10] = '{16'h050, 1'b1, 32'h7777_7777, 32'h0000_0000};
    vecs[11] = '{16'h010, 1'b1, 32'h8888_8888, 32'h0000_0000};
    vecs[12] = '{16'h008, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{16'h104, 1'b0, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    address = '0;
    write = 1'b0;
    writedata = '0;
    read = 1'b0;
    render_done = 1'b0;
    repeat (3) tick();
    checkOutput("reset_rdv", 32'(readdatavalid), 32'h0);
    checkOutput("reset_go", 32'(render_go), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_vb_base", 32'(vb_base), 32'h0030_0000);
    checkOutput("reset_fb_base", 32'(fb_base), 32'h0);
    reset = 1'b0;
    tick();

    busRead(16'h004, 32'h0030_0000);
    busRead(16'h000, 32'h0);
    busRead(16'h00C, 32'h0);
    busRead(16'h010, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) busWrite(vecs[i].addr, vecs[i].wdata);
      busRead(vecs[i].addr, vecs[i].exp);
    end

    // Same-cycle read and write returns the pre-write value
    applyStimulus(1'b1, 1'b1, 16'h300, 32'h0000_BEEF, 32'h0000_ABCD);
    busRead(16'h300, 32'h0000_BEEF);
    busRead(16'h00C, 32'h4);
    busWrite(16'h00C, 32'h4);
    busRead(16'h00C, 32'h0);
    checkOutput("mat0w0_before_start", mat[31:0], 32'h0);
    checkOutput("vb_before_start", 32'(vb_base), 32'h0030_0000);

    // Frame 1
    busWrite(16'h008, 32'h1);
    checkOutput("f1_go_commit", 32'(render_go), 32'h1);
    checkOutput("f1_busy_commit", 32'(busy), 32'h1);
    checkOutput("f1_mat_in_commit", mat[31:0], 32'h0);
    tick();
    checkOutput("f1_go_run", 32'(render_go), 32'h0);
    checkOutput("f1_mat0w0", mat[31:0], 32'h3F80_0000);
    checkOutput("f1_mat0w15", mat[511:480], 32'hDEAD_BEEF);
    checkOutput("f1_mat1w0", mat[543:512], 32'h1111_0000);
    checkOutput("f1_fb", 32'(fb_base), 32'h03FF_FFFF);
    checkOutput("f1_vb", 32'(vb_base), 32'h0234_5678);
    checkOutput("f1_light0", lighting[31:0], 32'h0000_BEEF);
    checkOutput("f1_light2", lighting[95:64], 32'hCAFE_F00D);
    repeat (3) tick();
    checkOutput("f1_busy_run", 32'(busy), 32'h1);
    pulseDone();
    #1;
    checkOutput("f1_busy_after", 32'(busy), 32'h0);
    checkOutput("f1_go_count", 32'(go_count), 32'd1);
    busRead(16'h00C, 32'h2);
    busRead(16'h010, 32'h1);
    busWrite(16'h00C, 32'h2);
    busRead(16'h00C, 32'h0);
    pulseDone();
    busRead(16'h010, 32'h1);
    busRead(16'h00C, 32'h0);

    // Frame 2: commit collision, double START, writes during RUN
    busWrite(16'h200, 32'h2222_0000);
    busWrite(16'h008, 32'h1);
    checkOutput("f2_go_commit", 32'(render_go), 32'h1);
    busWrite(16'h200, 32'h3333_0000);
    checkOutput("f2_mat1w0_old", mat[543:512], 32'h2222_0000);
    busRead(16'h200, 32'h3333_0000);
    busWrite(16'h008, 32'h1);
    busWrite(16'h100, 32'h4000_0000);
    tick();
    #1;
    checkOutput("f2_go_count", 32'(go_count), 32'd2);
    checkOutput("f2_mat0w0_held", mat[31:0], 32'h3F80_0000);
    checkOutput("f2_mat1w0_held", mat[543:512], 32'h2222_0000);
    busRead(16'h00C, 32'h5);
    pulseDone();
    busRead(16'h010, 32'h2);
    busRead(16'h00C, 32'h6);
    busWrite(16'h00C, 32'h6);
    busRead(16'h00C, 32'h0);

    // Frame 3: new shadow values commit; done set beats simultaneous W1C
    busWrite(16'h008, 32'h1);
    tick();
    checkOutput("f3_mat1w0", mat[543:512], 32'h3333_0000);
    checkOutput("f3_mat0w0", mat[31:0], 32'h4000_0000);
    render_done = 1'b1;
    busWrite(16'h00C, 32'h2);
    render_done = 1'b0;
    busRead(16'h00C, 32'h2);
    busRead(16'h010, 32'h3);
    busWrite(16'h00C, 32'h2);

    // Unmapped access
    busWrite(16'h050, 32'h1);
    busRead(16'h050, 32'h0);
    busRead(16'h00C, 32'h4);
    busWrite(16'h00C, 32'h4);

`ifdef RENDER_CFG_IRQ_EN
    busWrite(16'h014, 32'h1);
    busRead(16'h014, 32'h1);
    busRead(16'h00C, 32'h0);
    busWrite(16'h008, 32'h1);
    repeat (2) tick();
    checkOutput("irq_idle_low", 32'(irq), 32'h0);
    pulseDone();
    tick();
    checkOutput("irq_raised", 32'(irq), 32'h1);
    busWrite(16'h00C, 32'h2);
    tick();
    checkOutput("irq_cleared", 32'(irq), 32'h0);
`else
    busWrite(16'h014, 32'h1);
    busRead(16'h014, 32'h0);
    busRead(16'h00C, 32'h4);
    busWrite(16'h00C, 32'h4);
    busRead(16'h00C, 32'h0);
`endif

    // Reset in the middle of RUN aborts the frame without reporting done
    busWrite(16'h008, 32'h1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_run_busy", 32'(busy), 32'h0);
    checkOutput("rst_run_mat", mat[31:0], 32'h0);
    checkOutput("rst_run_vb", 32'(vb_base), 32'h0030_0000);
    tick();
    reset = 1'b0;
    tick();
    pulseDone();
    busRead(16'h00C, 32'h0);
    busRead(16'h010, 32'h0);
    busRead(16'h100, 32'h0);

    repeat (3) tick();
    while (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL missing_rdv: read@%03h got no response, expected 0x%08h", e.addr, e.data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/render_cfg_regs.md
Name: render_cfg_regs

Overview:
- Parametrised Avalon-MM slave register file for the 3D accelerator. It holds the frame/vertex buffer bases, NUM_MAT 4x4 matrices and the lighting words.
- All configuration is double-buffered. Host writes land in shadow registers; the active copy driven to the render pipeline changes only at frame launch.
- A small FSM sequences launch (START), busy, done and a frame counter between the host CPU and the render pipeline.

Parameters:
DATA_W, 32, bus and register word width
ADDR_W, 16, byte address width
BASE_W, 26, width of buffer base outputs
NUM_MAT, 2, number of matrices (matrix 0 = MV, 1 = MVP)
MAT_WORDS, 16, words per matrix
LIGHT_WORDS, 3, lighting words
VB_RESET, 26'h300000, reset value of vertex buffer base
CNT_W, 16, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  byte address, word aligned (bits [1:0] ignored)
write  in  1  write strobe
writedata  in  DATA_W  write data
read  in  1  read strobe
readdata  out  DATA_W  read data, valid with readdatavalid
readdatavalid  out  1  one-cycle read response pulse
fb_base  out  BASE_W  active frame buffer base
vb_base  out  BASE_W  active vertex buffer base
mat  out  NUM_MAT*MAT_WORDS*DATA_W  active matrices, matrix m word w at [(m*MAT_WORDS+w)*DATA_W +: DATA_W]
lighting  out  LIGHT_WORDS*DATA_W  active lighting words
render_go  out  1  one-cycle launch pulse to the pipeline
render_done  in  1  one-cycle frame-complete pulse from the pipeline
busy  out  1  frame in flight

Behaviour:
Address map (byte offsets):
- 0x000 FB_BASE
- 0x004 VB_BASE
- 0x008 CTRL: bit0 START, write-1, reads 0
- 0x00C STATUS: bit0 busy (RO), bit1 done (sticky, W1C), bit2 err (sticky, W1C)
- 0x010 FRAME_CNT (RO)
- 0x100*(m+1) + 4*w: matrix m word w
- 0x100*(NUM_MAT+1) + 4*k: lighting word k

Write and read path:
- Writes to FB_BASE, VB_BASE, matrix and lighting addresses update shadow only. Base registers take writedata[BASE_W-1:0].
- Writes to unmapped or read-only addresses are dropped and set err.
- Reads return the shadow value for config addresses, live values for STATUS/FRAME_CNT, and 0 for unmapped addresses.
- Read latency is 1 cycle: readdata and readdatavalid are registered in the cycle after read.
- If read and write arrive in the same cycle, the write is performed and the read returns the pre-write value.

FSM IDLE -> COMMIT -> RUN -> IDLE:
- IDLE: a START write moves to COMMIT.
- COMMIT (1 cycle): all shadow copied to active; render_go asserted this cycle; next state RUN.
  - A shadow write in the COMMIT cycle updates shadow only. Active receives the pre-write shadow value.
- RUN: busy = 1. On render_done: done <= 1, FRAME_CNT++ (wraps at 2^CNT_W), next state IDLE.
- A START write while in COMMIT or RUN is ignored and sets err.
- render_done while IDLE or COMMIT is ignored.
- If a done W1C write coincides with a new done set, the set wins.
- busy = (state != IDLE), including the COMMIT cycle.

Reset:
- All shadow and active registers reset to 0, except vb_base (both copies) = VB_RESET.
- readdata, readdatavalid, render_go, done, err and FRAME_CNT reset to 0; state resets to IDLE.
- Reset mid-RUN aborts immediately; no done is reported.

Optional Feature:
Macro: RENDER_CFG_IRQ_EN.
- With the macro defined:
  - Adds output irq (1 bit) and register 0x014 IRQ_EN: bit0 enables done, bit1 enables err.
  - irq = |(IRQ_EN & {err, done}), registered, reset 0.
- Without the macro:
  - No irq port.
  - 0x014 is unmapped: reads return 0, writes set err.

Decomposition:
- Package render_cfg_pkg holds:
  - address offset constants
  - CTRL/STATUS bit indices
  - FSM state enum (IDLE, COMMIT, RUN)
  - an address-decode function that returns region and index
- Sub-module cfg_shadow_bank (parameters WORDS, DATA_W, RESET_VAL): a word-array shadow plus active pair with write port, read mux and commit input. It is instantiated once per matrix and once for lighting; the base registers are handled inline.

Test Plan:
- Reset: read VB_BASE -> 0x00300000 with readdatavalid one cycle after read; FB_BASE, STATUS and FRAME_CNT read 0.
- Shadowing: write 0x3F800000 to 0x100, then read 0x100 -> 0x3F800000; mat[31:0] stays 0 until START, then equals 0x3F800000 in the cycle after the COMMIT cycle; render_go pulses exactly 1 cycle.
- Full frame: START -> busy = 1; render_done 5 cycles later -> busy = 0, STATUS = 0x2, FRAME_CNT = 1; write 0x2 to STATUS -> STATUS reads 0.
- Double START: write START again during RUN -> no second render_go, err = 1, and the active matrices are unchanged despite new shadow writes.
- COMMIT collision: write 0x200 in the same cycle as COMMIT -> active matrix 1 word 0 keeps the old shadow value and shadow holds the new value; a second frame commits the new value.
- Unmapped and feature: write 0x050 -> err = 1, read 0x050 -> 0. With RENDER_CFG_IRQ_EN and IRQ_EN = 1, completing a frame raises irq; clearing done drops irq.
